bus_rx_endpoint: RTL



---
 rtl/bus_rx_endpoint.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/bus_rx_endpoint.sv
// Byte-wide bus receiver: parses header + address bytes into a command for the
// local engine, then returns a one-cycle ack once the engine reports done.
module bus_rx_endpoint #(
  parameter int         ADDRW   = 24,
  parameter logic [1:0] DEV_ID  = 2'd1,
  parameter int         TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       bus_data,
  input  logic             bus_valid,
  output logic             bus_ready,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [1:0]       cmd_op,
  output logic [ADDRW-1:0] cmd_addr,
  input  logic             done_in,
  output logic             ack_out,
  output logic             err
);

  localparam int NBYTES = ADDRW / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_SKIP, S_ISSUE, S_BUSY, S_ACK
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [7:0]       r_bcnt;
  logic [7:0]       r_tcnt;
  logic             r_cmd_valid;
  logic [1:0]       r_cmd_op;
  logic [ADDRW-1:0] r_cmd_addr;
  logic             r_ack;
  logic             r_err;
  logic             w_xfer;
  logic             w_hdr_match;
  logic             w_last_byte;
  logic             w_timeout;
  logic             w_err_set;
  logic             w_hdr_accept;

  assign bus_ready    = (r_state == S_IDLE) || (r_state == S_ADDR) || (r_state == S_SKIP);
  assign w_xfer       = bus_valid & bus_ready;
  assign w_hdr_match  = (bus_data[7:6] == DEV_ID);
  assign w_last_byte  = (r_bcnt == 8'(NBYTES - 1));
  assign w_timeout    = !w_xfer && (r_tcnt == 8'(TIMEOUT - 1));
  assign w_hdr_accept = (r_state == S_IDLE) && w_xfer && w_hdr_match && (bus_data[5:4] != 2'b11);

  assign cmd_valid = r_cmd_valid;
  assign cmd_op    = r_cmd_op;
  assign cmd_addr  = r_cmd_addr;
  assign ack_out   = r_ack;
  assign err       = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_err_set    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          if (!w_hdr_match) begin
            w_state_next = S_SKIP;
          end else if (bus_data[5:4] == 2'b11) begin
            w_state_next = S_SKIP;
            w_err_set    = 1'b1;
          end else begin
            w_state_next = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (w_xfer && w_last_byte) begin
          w_state_next = S_ISSUE;
        end else if (w_timeout) begin
          w_state_next = S_IDLE;
          w_err_set    = 1'b1;
        end
      end
      S_SKIP: begin
        if (w_xfer && w_last_byte) begin
          w_state_next = S_IDLE;
        end else if (w_timeout) begin
          w_state_next = S_IDLE;
          w_err_set    = 1'b1;
        end
      end
      S_ISSUE: if (r_cmd_valid && cmd_ready) w_state_next = S_BUSY;
      S_BUSY:  if (done_in) w_state_next = S_ACK;
      S_ACK:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Byte and idle counters restart whenever the state changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcnt <= 8'd0;
      r_tcnt <= 8'd0;
    end else if (w_state_next != r_state) begin
      r_bcnt <= 8'd0;
      r_tcnt <= 8'd0;
    end else if (w_xfer) begin
      r_bcnt <= r_bcnt + 8'd1;
      r_tcnt <= 8'd0;
    end else if ((r_state == S_ADDR) || (r_state == S_SKIP)) begin
      r_tcnt <= r_tcnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_op   <= 2'd0;
      r_cmd_addr <= '0;
    end else if (w_hdr_accept) begin
      r_cmd_op   <= bus_data[5:4];
      r_cmd_addr <= '0;
    end else if ((r_state == S_ADDR) && w_xfer) begin
      r_cmd_addr[8*r_bcnt +: 8] <= bus_data;
    end
  end

  // cmd_valid rises one cycle after entering ISSUE and drops on the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_valid <= 1'b0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_cmd_valid <= (r_state == S_ISSUE) && (w_state_next == S_ISSUE);
      r_ack       <= (r_state == S_ACK);
      r_err       <= w_err_set;
    end
  end

endmodule
